multiplier_rr_scheduler: RTL

//  Shares one multiplier_bw_unsigned instance among NREQ requesters.
//  - Round-robin arbitration with valid/ready handshakes on both the request and response sides.
//  - Operands are registered and held stable while the combinational array settles.

---
 rtl/multiplier_rr_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/multiplier_rr_scheduler.sv
// multiplier_bw_unsigned: SIZE x SIZE unsigned array multiplier with a full 2*SIZE-bit product.
// Latency: purely combinational; the caller holds the inputs stable and times this as a multicycle path.
// Backpressure: none, there is no handshake at this level.
module multiplier_bw_unsigned #(
   parameter int SIZE = 32
) (
   input  logic [SIZE-1:0]   a,
   input  logic [SIZE-1:0]   b,
   output logic [2*SIZE-1:0] y
);

   logic [2*SIZE-1:0] acc;

   // Sum of shifted partial products, one row per bit of b
   always_comb begin
      acc = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (b[i]) begin
            acc = acc + ({{SIZE{1'b0}}, a} << i);
         end
      end
   end

   assign y = acc;

endmodule

// multiplier_rr_scheduler: round-robin sharing of one array multiplier among NREQ requesters.
// Latency: rsp_valid rises MUL_CYCLES edges after the accepting edge; one operation in flight at a time.
// Backpressure: the response holds until rsp_ready, and no new grant is offered until it drains.
module multiplier_rr_scheduler #(
   parameter int  SIZE       = 32,
   parameter int  NREQ       = 4,
   parameter int  MUL_CYCLES = 2,
   localparam int IDW        = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*SIZE-1:0] req_a,
   input  logic [NREQ*SIZE-1:0] req_b,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [2*SIZE-1:0]    rsp_y,
   output logic                 busy
);

   localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

   state_t            state;
   logic [IDW-1:0]    ptr;
   logic [IDW-1:0]    op_id;
   logic [CW-1:0]     cnt;
   logic [SIZE-1:0]   op_a;
   logic [SIZE-1:0]   op_b;
   logic [2*SIZE-1:0] prod;
   logic [IDW-1:0]    gnt;
   logic              gnt_vld;
   logic [IDW-1:0]    idx;

   // Rotating priority search: scanning from the far end down lets the entry closest to ptr win
   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      idx     = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IDW'((int'(ptr) + i) % NREQ);
         if (req_valid[idx]) begin
            gnt     = idx;
            gnt_vld = 1'b1;
         end
      end
   end

   // Grant is offered only while idle and out of reset, so a transfer equals grant-found in IDLE
   always_comb begin
      req_ready = '0;
      if (state == IDLE && !reset && gnt_vld) begin
         req_ready[gnt] = 1'b1;
      end
   end

   assign busy = (state != IDLE);

   // Inputs come straight from registers that only move on the accepting edge
   multiplier_bw_unsigned #(
      .SIZE (SIZE)
   ) u_mul (
      .a (op_a),
      .b (op_b),
      .y (prod)
   );

   // Control FSM: accept, let the array settle for MUL_CYCLES, then hold the product until taken
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_vld) begin
                  op_a  <= req_a[int'(gnt)*SIZE +: SIZE];
                  op_b  <= req_b[int'(gnt)*SIZE +: SIZE];
                  op_id <= gnt;
                  ptr   <= IDW'((int'(gnt) + 1) % NREQ);
                  cnt   <= CW'(MUL_CYCLES - 1);
                  state <= MUL;
               end
            end
            MUL: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else begin
                  rsp_y     <= prod;
                  rsp_id    <= op_id;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
